// File: rtl/alu_vectorial_pipe_if.sv
// alu_vectorial_pipe_if: handshake and data bus of the vector ALU pipeline
interface alu_vectorial_pipe_if #(
  parameter int ANCHO = 8,
  parameter int CARRILES = 4
);
  logic in_valid;
  logic in_ready;
  logic [3:0] opcode;
  logic [CARRILES*ANCHO-1:0] val_a;
  logic [CARRILES*ANCHO-1:0] val_b;
  logic [ANCHO-1:0] escalar;
  logic out_valid;
  logic out_ready;
  logic [CARRILES*ANCHO-1:0] resultado;
  logic op_invalida;
  logic [CARRILES-1:0] saturado;
  modport master (
    output in_valid, opcode, val_a, val_b, escalar, out_ready,
    input in_ready, out_valid, resultado, op_invalida, saturado
  );
  modport slave (
    input in_valid, opcode, val_a, val_b, escalar, out_ready,
    output in_ready, out_valid, resultado, op_invalida, saturado
  );
endinterface

// File: rtl/alu_vectorial_pipe.sv
// alu_vectorial_pipe: 2-stage lane-wise vector ALU; define ALU_VECTORIAL_SAT_EN for saturating add/sub
module alu_vectorial_pipe #(
  parameter int ANCHO = 8,
  parameter int CARRILES = 4
) (
  input logic clk,
  input logic reset,
  alu_vectorial_pipe_if.slave bus
);
  localparam int W = CARRILES * ANCHO;
  localparam int RB = $clog2(ANCHO);
  localparam logic [RB:0] AW = (RB + 1)'(ANCHO);
  logic s1_v, s2_v, s1_adv, s2_adv;
  logic [3:0] s1_op;
  logic [W-1:0] s1_a, s1_b, s2_res, res_c;
  logic [ANCHO-1:0] s1_e;
  logic s2_inv, inv_c, add_op, sub_op;
  logic [ANCHO-1:0] a, xa, xs, add_r, sub_r, rl, rr;
  logic [RB:0] r, sh;
`ifdef ALU_VECTORIAL_SAT_EN
  logic [ANCHO:0] sum, dif;
  logic [CARRILES-1:0] s2_sat, sat_c;
`endif
  assign s2_adv = !s2_v || bus.out_ready;
  assign s1_adv = !s1_v || s2_adv;
  assign bus.in_ready = !reset && s1_adv;
  assign bus.out_valid = s2_v;
  assign bus.resultado = s2_res;
  assign bus.op_invalida = s2_inv;
`ifdef ALU_VECTORIAL_SAT_EN
  assign bus.saturado = s2_sat;
`else
  assign bus.saturado = '0;
`endif
  // per-lane result of the operation held in S1; lanes never share carries
  always_comb begin
    res_c = '0;
    inv_c = !(s1_op inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF});
    add_op = s1_op inside {4'h1, 4'hA, 4'hF};
    sub_op = s1_op inside {4'h2, 4'hB};
    r = {1'b0, s1_e[RB-1:0]};
    sh = AW - r;
    a = '0;
    xa = '0;
    xs = '0;
    add_r = '0;
    sub_r = '0;
    rl = '0;
    rr = '0;
`ifdef ALU_VECTORIAL_SAT_EN
    sum = '0;
    dif = '0;
    sat_c = '0;
`endif
    for (int i = 0; i < CARRILES; i++) begin
      a = s1_a[i*ANCHO +: ANCHO];
      xa = (s1_op == 4'h1) ? s1_b[i*ANCHO +: ANCHO] : s1_e;
      xs = (s1_op == 4'h2) ? s1_b[i*ANCHO +: ANCHO] : s1_e;
`ifdef ALU_VECTORIAL_SAT_EN
      sum = {1'b0, a} + {1'b0, xa};
      dif = {1'b0, a} - {1'b0, xs};
      add_r = sum[ANCHO] ? '1 : sum[ANCHO-1:0];
      sub_r = dif[ANCHO] ? '0 : dif[ANCHO-1:0];
      sat_c[i] = (add_op && sum[ANCHO]) || (sub_op && dif[ANCHO]);
`else
      add_r = a + xa;
      sub_r = a - xs;
`endif
      rl = (a << r) | (a >> sh);
      rr = (a >> r) | (a << sh);
      res_c[i*ANCHO +: ANCHO] = add_op ? add_r :
                                sub_op ? sub_r :
                                (s1_op == 4'h5) ? a ^ s1_e :
                                (s1_op == 4'h6) ? a << s1_e :
                                (s1_op == 4'h7) ? a >> s1_e :
                                (s1_op == 4'h8) ? rl :
                                (s1_op == 4'h9) ? rr : '0;
    end
  end
  // S1 captures accepted operations, S2 holds results until taken downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s2_res <= '0;
      s2_inv <= 1'b0;
`ifdef ALU_VECTORIAL_SAT_EN
      s2_sat <= '0;
`endif
    end else begin
      if (s1_adv) s1_v <= bus.in_valid;
      if (s1_adv && bus.in_valid) {s1_op, s1_a, s1_b, s1_e} <= {bus.opcode, bus.val_a, bus.val_b, bus.escalar};
      if (s2_adv) s2_v <= s1_v;
      if (s2_adv && s1_v) begin
        s2_res <= res_c;
        s2_inv <= inv_c;
`ifdef ALU_VECTORIAL_SAT_EN
        s2_sat <= sat_c;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_vectorial_pipe.sv
// tb_alu_vectorial_pipe: scoreboard bench for the vector ALU pipeline
module tb_alu_vectorial_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  alu_vectorial_pipe_if #(.ANCHO(8), .CARRILES(4)) bus();
  alu_vectorial_pipe #(.ANCHO(8), .CARRILES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {
    logic [31:0] r;
    logic inv;
    logic [3:0] sat;
  } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  logic stall_p = 1'b0;
  logic [31:0] held_r;
  logic held_inv;
  logic [3:0] held_sat;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic exp_t lit(input logic [31:0] r, input logic inv, input logic [3:0] sat);
    return {r, inv, sat};
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [7:0] e);
    exp_t x;
    x = '0;
    for (int i = 0; i < 4; i++) begin
      int va, vb, s, r, v;
      va = int'(a[i*8 +: 8]);
      vb = int'(b[i*8 +: 8]);
      s = int'(e);
      r = s % 8;
      v = 0;
      case (op)
        4'h1: v = va + vb;
        4'h2: v = va - vb;
        4'h5: v = va ^ s;
        4'h6: v = (s >= 8) ? 0 : va << s;
        4'h7: v = (s >= 8) ? 0 : va >> s;
        4'h8: v = (va << r) | (va >> (8 - r));
        4'h9: v = (va >> r) | (va << (8 - r));
        4'hA, 4'hF: v = va + s;
        4'hB: v = va - s;
        default: x.inv = 1'b1;
      endcase
`ifdef ALU_VECTORIAL_SAT_EN
      if ((op == 4'h1 || op == 4'hA || op == 4'hF) && v > 255) begin
        v = 255;
        x.sat[i] = 1'b1;
      end
      if ((op == 4'h2 || op == 4'hB) && v < 0) begin
        v = 0;
        x.sat[i] = 1'b1;
      end
`endif
      x.r[i*8 +: 8] = v[7:0];
    end
    return x;
  endfunction

  task automatic sendx(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [7:0] e, input exp_t x);
    int t;
    t = 0;
    q.push_back(x);
    bus.in_valid = 1'b1;
    bus.opcode = op;
    bus.val_a = a;
    bus.val_b = b;
    bus.escalar = e;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [7:0] e);
    sendx(op, a, b, e, model(op, a, b, e));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (stall_p) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_res", bus.resultado, held_r);
      chk("hold_inv", bus.op_invalida, held_inv);
      chk("hold_sat", bus.saturado, held_sat);
    end
    stall_p = bus.out_valid && !bus.out_ready && !reset;
    held_r = bus.resultado;
    held_inv = bus.op_invalida;
    held_sat = bus.saturado;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("unexpected_out", bus.out_valid, 0);
      else begin
        x = q.pop_front();
        chk("res", bus.resultado, x.r);
        chk("inv", bus.op_invalida, x.inv);
        chk("sat", bus.saturado, x.sat);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.opcode = '0;
    bus.val_a = '0;
    bus.val_b = '0;
    bus.escalar = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_res", bus.resultado, 0);
    chk("rst_inv", bus.op_invalida, 0);
    chk("rst_sat", bus.saturado, 0);
    chk("rst_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
`ifdef ALU_VECTORIAL_SAT_EN
    sendx(4'h1, 32'h007FFF10, 32'h00011001, 8'h00, lit(32'h0080FF11, 1'b0, 4'b0010));
`else
    sendx(4'h1, 32'h007FFF10, 32'h00011001, 8'h00, lit(32'h00800F11, 1'b0, 4'b0000));
`endif
    @(negedge clk);
    chk("lat1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat2_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    sendx(4'h8, 32'h81818181, 32'h0, 8'd1, lit(32'h03030303, 1'b0, 4'b0));
    sendx(4'h8, 32'h81818181, 32'h0, 8'd0, lit(32'h81818181, 1'b0, 4'b0));
    sendx(4'h8, 32'h81818181, 32'h0, 8'd9, lit(32'h03030303, 1'b0, 4'b0));
    sendx(4'h6, 32'h81818181, 32'h0, 8'd8, lit(32'h00000000, 1'b0, 4'b0));
    sendx(4'h9, 32'h81818181, 32'h0, 8'd1, lit(32'hC0C0C0C0, 1'b0, 4'b0));
    sendx(4'h3, 32'h12345678, 32'h9ABCDEF0, 8'h55, lit(32'h0, 1'b1, 4'b0));
`ifdef ALU_VECTORIAL_SAT_EN
    sendx(4'hA, 32'hF0F0F0F0, 32'h0, 8'h20, lit(32'hFFFFFFFF, 1'b0, 4'b1111));
    sendx(4'h2, 32'h05050505, 32'h09090909, 8'h00, lit(32'h00000000, 1'b0, 4'b1111));
`else
    sendx(4'hA, 32'hF0F0F0F0, 32'h0, 8'h20, lit(32'h10101010, 1'b0, 4'b0));
    sendx(4'h2, 32'h05050505, 32'h09090909, 8'h00, lit(32'hFCFCFCFC, 1'b0, 4'b0));
`endif
    drain();
    bus.out_ready = 1'b0;
    send(4'h1, 32'h01020304, 32'h01010101, 8'h00);
    send(4'h2, 32'h10101010, 32'h01010101, 8'h00);
    q.push_back(model(4'h5, 32'hAAAAAAAA, 32'h0, 8'hFF));
    bus.in_valid = 1'b1;
    bus.opcode = 4'h5;
    bus.val_a = 32'hAAAAAAAA;
    bus.val_b = 32'h0;
    bus.escalar = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("z_blocked", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("z_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();
    bus.out_ready = 1'b0;
    send(4'h1, 32'h11111111, 32'h22222222, 8'h00);
    send(4'hB, 32'h44444444, 32'h0, 8'h04);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.opcode = 4'h1;
    bus.val_a = 32'h01010101;
    @(negedge clk);
    chk("ready_in_rst", bus.in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_valid", bus.out_valid, 0);
    chk("ready_post_rst", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_ghost", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(4'h7, 32'h80402010, 32'h0, 8'd3);
    @(negedge clk);
    chk("rlat1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("rlat2_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 40; k++)
          send(4'($urandom_range(0, 15)), $urandom, $urandom, 8'($urandom_range(0, 15)));
      end
      begin
        for (int k = 0; k < 150; k++) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_vectorial_pipe.md
ALU_VECTORIAL_PIPE -- requirements
Module: alu_vectorial_pipe

Interface
REQ-001 Parameter: ANCHO, 8, lane width in bits; power of two, 4..32.
REQ-002 Parameter: CARRILES, 4, number of parallel lanes, 1..16.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operation present on input bus.
REQ-006 Port: in_ready  output  1  block accepts operation this cycle.
REQ-007 Port: opcode  input  4  operation select.
REQ-008 Port: val_a  input  CARRILES*ANCHO  vector operand A; lane i at bits [i*ANCHO +: ANCHO].
REQ-009 Port: val_b  input  CARRILES*ANCHO  vector operand B, same packing.
REQ-010 Port: escalar  input  ANCHO  scalar operand / shift amount / offset.
REQ-011 Port: out_valid  output  1  result present on output bus.
REQ-012 Port: out_ready  input  1  downstream accepts result this cycle.
REQ-013 Port: resultado  output  CARRILES*ANCHO  per-lane result, same packing.
REQ-014 Port: op_invalida  output  1  result belongs to an undefined opcode.
REQ-015 Port: saturado  output  CARRILES  per-lane saturation flag.

Function
REQ-016 Transfer in = in_valid && in_ready at a rising edge; transfer out = out_valid && out_ready.
REQ-017 Two register stages: S1 captures opcode/operands; S2 holds computed result; latency 2 cycles, throughput 1 op/cycle while out_ready=1.
REQ-018 S2 advances when S2 empty or out_ready=1; S1 advances when S1 empty or S2 advances; in_ready = S1 empty or S1 advances (combinational, no dependency on in_valid).
REQ-019 While out_valid=1 and out_ready=0, resultado, op_invalida, saturado shall hold stable; no operation lost, duplicated or reordered.
REQ-020 Opcodes, per lane, modulo 2^ANCHO: 0001 A+B; 0010 A-B; 0101 A^escalar; 0110 A<<escalar; 0111 A>>escalar (logical); 1000 rotate-left A by escalar; 1001 rotate-right A by escalar; 1010 A+escalar; 1011 A-escalar; 1111 A+escalar (VFS offset).
REQ-021 Logical shifts with escalar >= ANCHO yield 0.
REQ-022 Rotates use escalar mod ANCHO; amount 0 returns A unchanged.
REQ-023 Any other opcode yields resultado=0, saturado=0, op_invalida=1; op_invalida=0 for defined opcodes.
REQ-024 Lanes are independent; no carry or borrow crosses lane boundaries.
REQ-025 Without saturation feature, saturado shall be constant 0.

Reset
REQ-026 reset=1 at a rising edge empties S1 and S2: out_valid=0, resultado=0, op_invalida=0, saturado=0.
REQ-027 in_ready shall be 0 while reset=1, and 1 in the first cycle after reset deasserts.
REQ-028 Operations in flight when reset asserts are discarded; no result for them is ever presented.
REQ-029 in_valid during reset is ignored.

Configuration
REQ-030 Macro ALU_VECTORIAL_SAT_EN defined: opcodes 0001, 1010, 1111 clamp to 2^ANCHO-1 on unsigned overflow, opcodes 0010, 1011 clamp to 0 on underflow, and the lane's saturado bit is 1 for that result.
REQ-031 Macro ALU_VECTORIAL_SAT_EN undefined: all arithmetic wraps modulo 2^ANCHO and saturado is tied to 0; no saturation logic is synthesised.

Verification (ANCHO=8, CARRILES=4)
REQ-032 Add: opcode 0001, A lanes {0x10,0xFF,0x7F,0x00}, B lanes {0x01,0x10,0x01,0x00}, out_ready=1 -> 2 cycles later resultado lanes {0x11,0x0F,0x80,0x00} (no macro), op_invalida=0.
REQ-033 Rotate: opcode 1000, A=0x81 all lanes, escalar=1 -> 0x03; escalar=0 -> 0x81; escalar=9 -> 0x03; opcode 0110 escalar=8 -> 0x00.
REQ-034 Backpressure: out_ready=0, issue ops X,Y,Z back-to-back -> X,Y accepted, in_ready=0 on Z until out_ready=1; X,Y,Z then emerge in order, resultado stable while stalled.
REQ-035 Invalid: opcode 0011 with nonzero operands -> resultado=0, op_invalida=1, saturado=0.
REQ-036 Saturation: opcode 1010, A=0xF0, escalar=0x20 -> with ALU_VECTORIAL_SAT_EN resultado=0xFF, saturado=4'b1111; without, resultado=0x10, saturado=0; opcode 0010 A=0x05 B=0x09 -> 0x00 / 0xFC.
REQ-037 Reset mid-operation: accept two ops, assert reset one cycle with out_ready=0 -> out_valid=0 next cycle, neither op ever appears; new op after reset emerges with latency 2.
